// File: rtl/nv_nvdla_rubik_wcmd_seq.sv
// Rubik write-command sequencer: turns each write command into one DMA header beat plus len+1 data beats.
// Optional stall counter output is enabled by defining NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN.
module nv_nvdla_rubik_wcmd_seq (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rst,
    input  logic         wcmd_pvld,
    output logic         wcmd_prdy,
    input  logic [10:0]  wcmd_pd,
    input  logic         dat_pvld,
    output logic         dat_prdy,
    input  logic [255:0] dat_pd,
    output logic         dma_wr_req_pvld,
    input  logic         dma_wr_req_prdy,
    output logic         dma_wr_req_hdr,
    output logic [255:0] dma_wr_req_pd,
    input  logic [31:0]  reg2dp_dst_base_addr,
    output logic         layer_done
`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
    ,
    output logic [31:0]  wcmd_seq_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic        last_q, last_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic        fresh_q, fresh_d;
    logic        layer_done_q, layer_done_d;
    logic        beat_acc;
    logic        unused_rsvd;

    assign unused_rsvd = ^wcmd_pd[10:9];
    assign beat_acc    = dat_pvld && dma_wr_req_prdy;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d         = state_q;
        len_d           = len_q;
        last_d          = last_q;
        beat_cnt_d      = beat_cnt_q;
        cur_addr_d      = cur_addr_q;
        fresh_d         = fresh_q;
        layer_done_d    = 1'b0;
        wcmd_prdy       = 1'b0;
        dat_prdy        = 1'b0;
        dma_wr_req_pvld = 1'b0;
        dma_wr_req_hdr  = 1'b0;
        dma_wr_req_pd   = '0;

        case (state_q)
            ST_IDLE: begin
                wcmd_prdy = 1'b1;
                // At the start of a layer the address tracks the base register until a command arrives.
                if (fresh_q) begin
                    cur_addr_d = reg2dp_dst_base_addr;
                end
                if (wcmd_pvld) begin
                    len_d   = wcmd_pd[7:0];
                    last_d  = wcmd_pd[8];
                    fresh_d = 1'b0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                dma_wr_req_pvld = 1'b1;
                dma_wr_req_hdr  = 1'b1;
                dma_wr_req_pd   = {216'b0, len_q, cur_addr_q};
                if (dma_wr_req_prdy) begin
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                dma_wr_req_pvld = dat_pvld;
                dat_prdy        = dma_wr_req_prdy;
                dma_wr_req_pd   = dat_pd;
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == len_q) begin
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                        if (last_q) begin
                            cur_addr_d   = reg2dp_dst_base_addr;
                            fresh_d      = 1'b1;
                            layer_done_d = 1'b1;
                        end else begin
                            cur_addr_d = cur_addr_q + {19'b0, len_q, 5'b0} + 32'd32;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset branch is synchronous.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            last_q       <= 1'b0;
            beat_cnt_q   <= '0;
            cur_addr_q   <= '0;
            fresh_q      <= 1'b1;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            last_q       <= last_d;
            beat_cnt_q   <= beat_cnt_d;
            cur_addr_q   <= cur_addr_d;
            fresh_q      <= fresh_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign layer_done = layer_done_q;

`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (layer_done_q) begin
            stall_cnt_d = '0;
        end else if (dma_wr_req_pvld && !dma_wr_req_prdy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wcmd_seq_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_rubik_wcmd_seq.sv
// Directed plus randomized bench for nv_nvdla_rubik_wcmd_seq; checks the stall counter when
// NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN is defined.
module tb_nv_nvdla_rubik_wcmd_seq;

    logic         clk;
    logic         rst;
    logic         wcmd_pvld;
    logic         wcmd_prdy;
    logic [10:0]  wcmd_pd;
    logic         dat_pvld;
    logic         dat_prdy;
    logic [255:0] dat_pd;
    logic         dma_wr_req_pvld;
    logic         dma_wr_req_prdy;
    logic         dma_wr_req_hdr;
    logic [255:0] dma_wr_req_pd;
    logic [31:0]  base;
    logic         layer_done;
`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
    logic [31:0]  stall_cnt;
`endif

    int          n_assert;
    int          n_fail;
    logic [31:0] exp_addr;
    int          stall_model;

    nv_nvdla_rubik_wcmd_seq dut (
        .nvdla_core_clk       (clk),
        .nvdla_core_rst       (rst),
        .wcmd_pvld            (wcmd_pvld),
        .wcmd_prdy            (wcmd_prdy),
        .wcmd_pd              (wcmd_pd),
        .dat_pvld             (dat_pvld),
        .dat_prdy             (dat_prdy),
        .dat_pd               (dat_pd),
        .dma_wr_req_pvld      (dma_wr_req_pvld),
        .dma_wr_req_prdy      (dma_wr_req_prdy),
        .dma_wr_req_hdr       (dma_wr_req_hdr),
        .dma_wr_req_pd        (dma_wr_req_pd),
        .reg2dp_dst_base_addr (base),
        .layer_done           (layer_done)
`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
        ,
        .wcmd_seq_stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Base may only change at a layer boundary, where the next header must use it.
    task automatic set_base(input logic [31:0] b);
        base     = b;
        exp_addr = b;
    endtask

    // One command: header, len+1 data beats, optional stalls; abort_after>=0 stops after that many beats.
    task automatic run_cmd(input logic [7:0] len, input logic last, input int hdr_stall,
                           input int dat_stall, input bit rnd, input int abort_after);
        logic [255:0] d;
        int           acc;
        int           budget;
        int           dl;
        bit           new_data;

        @(negedge clk);
        wcmd_pvld = 1'b1;
        wcmd_pd   = {2'($urandom), last, len};
        #1;
        check("idle_wcmd_prdy", wcmd_prdy, 1'b1);
        check("idle_req_pvld", dma_wr_req_pvld, 1'b0);

        for (int k = 0; k <= hdr_stall; k++) begin
            @(negedge clk);
            wcmd_pvld       = 1'b0;
            wcmd_pd         = 11'($urandom);
            dma_wr_req_prdy = (k == hdr_stall);
            #1;
            check("hdr_pvld", dma_wr_req_pvld, 1'b1);
            check("hdr_flag", dma_wr_req_hdr, 1'b1);
            check("hdr_pd", dma_wr_req_pd, {216'b0, len, exp_addr});
            check("hdr_wcmd_prdy", wcmd_prdy, 1'b0);
            check("hdr_dat_prdy", dat_prdy, 1'b0);
            if (k < hdr_stall) stall_model++;
        end

        acc      = 0;
        budget   = 0;
        dl       = dat_stall;
        new_data = 1'b1;
        d        = '0;
        while (acc <= int'(len) && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (new_data) d = rand256();
            dat_pd = d;
            if (acc == int'(len) / 2 && dl > 0) begin
                dat_pvld        = 1'b1;
                dma_wr_req_prdy = 1'b0;
                dl--;
            end else if (rnd) begin
                dat_pvld        = ($urandom_range(0, 3) != 0);
                dma_wr_req_prdy = ($urandom_range(0, 3) != 0);
            end else begin
                dat_pvld        = 1'b1;
                dma_wr_req_prdy = 1'b1;
            end
            #1;
            check("data_pvld", dma_wr_req_pvld, dat_pvld);
            check("data_dat_prdy", dat_prdy, dma_wr_req_prdy);
            check("data_wcmd_prdy", wcmd_prdy, 1'b0);
            check("data_layer_done", layer_done, 1'b0);
            if (dat_pvld) begin
                check("data_hdr", dma_wr_req_hdr, 1'b0);
                check("data_pd", dma_wr_req_pd, d);
            end
            if (dat_pvld && !dma_wr_req_prdy) stall_model++;
            new_data = !dat_pvld || dma_wr_req_prdy;
            if (dat_pvld && dma_wr_req_prdy) acc++;
            if (abort_after >= 0 && acc == abort_after) return;
        end
        check("beats_done", acc, int'(len) + 1);

        @(negedge clk);
        dat_pvld = 1'b0;
        #1;
        check("end_wcmd_prdy", wcmd_prdy, 1'b1);
        check("end_req_pvld", dma_wr_req_pvld, 1'b0);
        check("end_dat_prdy", dat_prdy, 1'b0);
        check("end_layer_done", layer_done, last);
`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
        check("stall_cnt", stall_cnt, stall_model);
`endif
        if (last) begin
            exp_addr = base;
            @(negedge clk);
            #1;
            check("layer_done_single", layer_done, 1'b0);
`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
            check("stall_cnt_clear", stall_cnt, 32'd0);
`endif
            stall_model = 0;
        end else begin
            exp_addr = exp_addr + (32'(len) + 32'd1) * 32'd32;
        end
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        stall_model     = 0;
        rst             = 1'b1;
        wcmd_pvld       = 1'b0;
        wcmd_pd         = '0;
        dat_pvld        = 1'b0;
        dat_pd          = '0;
        dma_wr_req_prdy = 1'b1;
        set_base(32'h0000_1000);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wcmd_prdy", wcmd_prdy, 1'b1);
        check("rst_req_pvld", dma_wr_req_pvld, 1'b0);
        check("rst_dat_prdy", dat_prdy, 1'b0);
        check("rst_layer_done", layer_done, 1'b0);
`ifdef NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

        // 0x1000 len 3, then next header at 0x1080 (closes the layer).
        run_cmd(8'd3, 1'b0, 0, 0, 1'b0, -1);
        run_cmd(8'd0, 1'b1, 0, 0, 1'b0, -1);

        // Two-command layer: 0x1000 then 0x1020, one layer_done, next header back at base.
        run_cmd(8'd0, 1'b0, 0, 0, 1'b0, -1);
        run_cmd(8'd1, 1'b1, 0, 0, 1'b0, -1);

        // Back-pressure held 5 cycles in header and mid-data.
        run_cmd(8'd6, 1'b1, 5, 5, 1'b0, -1);

        // Exactly 7 stalled cycles in a fresh layer.
        run_cmd(8'd2, 1'b1, 3, 4, 1'b0, -1);

        // Maximum length with wrap-around of the destination address.
        set_base(32'hFFFF_F000);
        run_cmd(8'd255, 1'b0, 0, 0, 1'b0, -1);
        check("wrap_addr_model", exp_addr, 32'h0000_1000);
        run_cmd(8'd0, 1'b1, 0, 0, 1'b0, -1);

        // Reset after 2 of 4 beats of the second command in a layer.
        set_base(32'h0000_1000);
        run_cmd(8'd1, 1'b0, 0, 0, 1'b0, -1);
        run_cmd(8'd3, 1'b0, 0, 0, 1'b0, 2);
        @(negedge clk);
        dat_pvld        = 1'b0;
        dma_wr_req_prdy = 1'b1;
        rst             = 1'b1;
        #1;
        check("abort_no_layer_done", layer_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_wcmd_prdy", wcmd_prdy, 1'b1);
        check("abort_req_pvld", dma_wr_req_pvld, 1'b0);
        check("abort_dat_prdy", dat_prdy, 1'b0);
        check("abort_layer_done", layer_done, 1'b0);
        exp_addr    = base;
        stall_model = 0;
        run_cmd(8'd2, 1'b0, 0, 0, 1'b0, -1);

        // Randomized commands with random handshakes.
        for (int i = 0; i < 8; i++) begin
            run_cmd(8'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, -1);
        end
        run_cmd(8'd4, 1'b1, 1, 1, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_rubik_wcmd_seq.md
NV_NVDLA_RUBIK_WCMD_SEQ -- requirements
Module: NV_NVDLA_RUBIK_wcmd_seq

Interface
REQ-001 SHALL provide one clock and a synchronous, active-high reset; there is no other clock or reset.
REQ-002 nvdla_core_clk  in  1  core clock; all state updates on its rising edge.
REQ-003 nvdla_core_rst  in  1  reset, synchronous, active-high.
REQ-004 wcmd_pvld  in  1  write command valid, from the write-command FIFO output.
REQ-005 wcmd_prdy  out  1  write command ready.
REQ-006 wcmd_pd  in  11  [7:0] beats-1, [8] is_last (final command of layer), [10:9] reserved (ignored).
REQ-007 dat_pvld  in  1  write data beat valid.
REQ-008 dat_prdy  out  1  write data beat ready.
REQ-009 dat_pd  in  256  write data beat.
REQ-010 dma_wr_req_pvld  out  1  DMA write request valid.
REQ-011 dma_wr_req_prdy  in  1  DMA write request ready.
REQ-012 dma_wr_req_hdr  out  1  1 = header beat, 0 = data beat.
REQ-013 dma_wr_req_pd  out  256  header: [31:0] addr, [39:32] beats-1, rest 0; data: dat_pd.
REQ-014 reg2dp_dst_base_addr  in  32  layer destination base byte address, quasi-static.
REQ-015 layer_done  out  1  one-cycle pulse when the is_last command's final beat is accepted.

Function
REQ-016 SHALL implement FSM IDLE, HDR, DATA; reset state IDLE.
REQ-017 IDLE: wcmd_prdy=1; on wcmd_pvld, latch len=wcmd_pd[7:0] and last=wcmd_pd[8], then go to HDR.
REQ-018 HDR: dma_wr_req_pvld=1, hdr=1, pd={216'b0, len, cur_addr}; on prdy, go to DATA and clear the beat counter.
REQ-019 DATA: dma_wr_req_pvld=dat_pvld, dat_prdy=dma_wr_req_prdy, pd=dat_pd, hdr=0, combinational pass-through with no added latency.
REQ-020 In DATA, each accepted beat increments an 8-bit beat counter; the beat accepted when counter==len is the final beat.
REQ-021 On the final beat: cur_addr += (len+1)*32 (zero-extended, modulo 2^32); if last=1, cur_addr reloads reg2dp_dst_base_addr instead and layer_done pulses the next cycle; FSM returns to IDLE.
REQ-022 wcmd_prdy=0 outside IDLE; dat_prdy=0 outside DATA; dma_wr_req_pvld=0 in IDLE.
REQ-023 A command accepted in cycle N yields a header valid in cycle N+1; the minimum command-to-command spacing is len+3 cycles.
REQ-024 len=255 yields 256 beats; the 8-bit counter does not wrap before the final beat.
REQ-025 The header and data outputs SHALL remain stable while pvld=1 and prdy=0.
REQ-026 cur_addr loads reg2dp_dst_base_addr whenever the FSM is in IDLE and no command has been accepted since reset or the last layer_done.

Reset
REQ-027 On reset: FSM=IDLE, beat counter=0, len/last=0, cur_addr reloads base on first use, layer_done=0, dma_wr_req_pvld=0, dat_prdy=0, wcmd_prdy=1 after reset deasserts.
REQ-028 Reset asserted mid-command aborts it: no further beats, no layer_done, and no address update.

Configuration
REQ-029 Macro NV_NVDLA_RUBIK_WCMD_SEQ_PERF_EN, when defined, SHALL add output wcmd_seq_stall_cnt[31:0], counting cycles with dma_wr_req_pvld=1 and prdy=0, saturating at 0xFFFFFFFF, cleared by reset and on layer_done.
REQ-030 Without the macro, the port and counter are absent; all other behaviour is identical.

Verification
REQ-031 base=0x1000, cmd len=3 last=0, prdy=1 -> header addr 0x1000 len 3, then 4 data beats, next header addr 0x1080.
REQ-032 cmds len=0 last=0 then len=1 last=1 -> headers 0x1000 and 0x1020, layer_done pulses once after the 2nd beat of cmd 2, next header 0x1000.
REQ-033 dma_wr_req_prdy low 5 cycles during HDR and mid-DATA -> pd/hdr held stable, no beat lost or duplicated, dat_prdy low.
REQ-034 len=255, base=0xFFFFF000 -> 256 data beats, next addr wraps to 0x00001000.
REQ-035 reset after 2 of 4 beats -> FSM IDLE, wcmd_prdy=1, no layer_done, next header uses base.
REQ-036 with PERF_EN, 7 stalled cycles -> wcmd_seq_stall_cnt=7; clears after layer_done.
